// File: rtl/regfile_dbg_pkg.sv
// Shared types and helpers for the register-unit debug dump reader.
package regfile_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        FETCH,
        SEND,
        TRAILER,
        DONE
    } dump_state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    function automatic int byte_count(input int xlen);
        return xlen / 8;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_serializer.sv
// Holds the bytes of one register word that are still to be sent, LSB first.
module word_byte_serializer
    import regfile_dbg_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_word,
    input  logic            i_advance,
    output logic [7:0]      o_next,
    output logic            o_last
);

    localparam int NB = byte_count(XLEN);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [XLEN-1:0] r_rest;
    logic [CW-1:0]   r_cnt;

    // Byte 0 goes straight out on load; r_rest keeps only the bytes behind it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rest <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_rest <= i_word >> 8;
            r_cnt  <= '0;
        end else if (i_advance && !o_last) begin
            r_rest <= r_rest >> 8;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_next = r_rest[7:0];
    assign o_last = (r_cnt == CW'(NB - 1));

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks every register through one read port and streams header,
// register bytes and an XOR checksum over a valid/ready byte interface.
module regfile_dump_reader
    import regfile_dbg_pkg::*;
#(
    parameter int          NUM_REGS  = 32,
    parameter int          XLEN      = 32,
    parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE,
    localparam int         AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            DRStart,
    output logic [AW-1:0]   DRAddr,
    input  logic [XLEN-1:0] DRData,
    output logic            DRHold,
    output logic [7:0]      DRByte,
    output logic            DRValid,
    input  logic            DRReady,
    output logic            DRBusy,
    output logic            DRDone
);

    dump_state_t   r_state;
    logic [AW-1:0] r_index;
    logic [7:0]    r_chk;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;

    logic          w_xfer;
    logic          w_load;
    logic          w_advance;
    logic          w_last;
    logic [7:0]    w_next;

    assign w_xfer    = r_valid && DRReady;
    assign w_load    = (r_state == FETCH);
    assign w_advance = (r_state == SEND) && w_xfer;

    word_byte_serializer #(
        .XLEN(XLEN)
    ) u_ser (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_load   (w_load),
        .i_word   (DRData),
        .i_advance(w_advance),
        .o_next   (w_next),
        .o_last   (w_last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_index <= '0;
            r_chk   <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (DRStart) begin
                        r_state <= HEADER;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                        r_byte  <= SYNC_BYTE;
                    end
                end
                HEADER: begin
                    if (w_xfer) begin
                        r_state <= FETCH;
                        r_valid <= 1'b0;
                    end
                end
                FETCH: begin
                    r_state <= SEND;
                    r_valid <= 1'b1;
                    r_byte  <= DRData[7:0];
                end
                SEND: begin
                    if (w_xfer) begin
                        r_chk <= r_chk ^ r_byte;
                        if (!w_last) begin
                            r_byte <= w_next;
                        end else if (r_index == AW'(NUM_REGS - 1)) begin
                            // Trailer folds in the byte leaving on this edge.
                            r_state <= TRAILER;
                            r_byte  <= r_chk ^ r_byte;
                        end else begin
                            r_index <= r_index + 1'b1;
                            r_state <= FETCH;
                            r_valid <= 1'b0;
                        end
                    end
                end
                TRAILER: begin
                    if (w_xfer) begin
                        r_state <= DONE;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_index <= '0;
                    r_chk   <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign DRAddr  = r_index;
    assign DRHold  = r_busy;
    assign DRBusy  = r_busy;
    assign DRByte  = r_byte;
    assign DRValid = r_valid;
    assign DRDone  = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomised, self-checking bench: a byte-stream model built from the
// register image is compared against every transferred byte.
module tb_regfile_dump_reader;
    import regfile_dbg_pkg::*;

    localparam int NR   = 32;
    localparam int XL   = 32;
    localparam int NB   = XL / 8;
    localparam int SLEN = 1 + NR * NB + 1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        DRStart;
    logic [4:0]  DRAddr;
    logic [31:0] DRData;
    logic        DRHold;
    logic [7:0]  DRByte;
    logic        DRValid;
    logic        DRReady;
    logic        DRBusy;
    logic        DRDone;

    logic [31:0] regs [NR];

    assign DRData = regs[DRAddr];

    regfile_dump_reader dut (
        .CLK    (CLK),
        .RST    (RST),
        .DRStart(DRStart),
        .DRAddr (DRAddr),
        .DRData (DRData),
        .DRHold (DRHold),
        .DRByte (DRByte),
        .DRValid(DRValid),
        .DRReady(DRReady),
        .DRBusy (DRBusy),
        .DRDone (DRDone)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rx_q [$];
    int         rx_n, done_n, done_edge, first_edge, last_edge, e0;
    bit         prev_stall;
    logic [7:0] prev_byte;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic build_expected();
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < NB; k++) begin
                b = regs[r][8*k +: 8];
                exp_q.push_back(b);
                x = x ^ b;
            end
        end
        exp_q.push_back(x);
    endtask

    task automatic clear_obs();
        rx_q.delete();
        rx_n       = 0;
        done_n     = 0;
        done_edge  = -1;
        first_edge = -1;
        last_edge  = -1;
        prev_stall = 0;
    endtask

    task automatic monitor();
        logic [7:0] e;
        if (RST) begin
            prev_stall = 0;
            return;
        end
        if (DRValid && DRReady) begin
            if (exp_q.size() == 0) begin
                chk("extra_byte", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("byte%0d", rx_n), DRByte, e);
            end
            if (rx_n == 0) first_edge = cyc + 1;
            last_edge = cyc + 1;
            rx_q.push_back(DRByte);
            rx_n++;
        end
        if (prev_stall) begin
            chk("stall_valid", DRValid, 1);
            chk("stall_byte", DRByte, prev_byte);
        end
        prev_stall = DRValid && !DRReady;
        prev_byte  = DRByte;
        chk("hold_eq_busy", DRHold, DRBusy);
        if (DRDone) begin
            done_n++;
            done_edge = cyc;
            chk("done_early", exp_q.size(), 0);
        end
    endtask

    task automatic start_dump();
        build_expected();
        clear_obs();
        @(posedge CLK);
        #1 DRStart = 1'b1;
        e0 = cyc + 1;
        @(posedge CLK);
        #1 DRStart = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int n = 0;
        while (done_n == 0 && n < budget) begin
            @(posedge CLK);
            #1;
            if (rnd) DRReady = ($urandom_range(0, 3) != 0);
            n++;
        end
        chk("done_timeout", done_n != 0, 1);
        DRReady = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
    endtask

    task automatic preload_basic();
        for (int r = 0; r < NR; r++) regs[r] = 32'h0;
        regs[1]  = 32'h5;
        regs[31] = 32'hFFFFFFFF;
    endtask

    task automatic check_zero_outputs(input string nm);
        chk({nm, "_addr"}, DRAddr, 0);
        chk({nm, "_byte"}, DRByte, 0);
        chk({nm, "_valid"}, DRValid, 0);
        chk({nm, "_busy"}, DRBusy, 0);
        chk({nm, "_hold"}, DRHold, 0);
        chk({nm, "_done"}, DRDone, 0);
    endtask

    initial begin
        int exp_a;
        int n;
        RST     = 1'b1;
        DRStart = 1'b0;
        DRReady = 1'b1;
        preload_basic();
        clear_obs();
        fork
            forever begin
                @(negedge CLK);
                monitor();
            end
        join_none
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // Full dump with fixed timing
        build_expected();
        chk("model_len", exp_q.size(), SLEN);
        chk("model_hdr", exp_q[0], 8'hA5);
        chk("model_x1b0", exp_q[5], 8'h05);
        chk("model_chk", exp_q[SLEN-1], 8'h05);
        start_dump();
        for (int i = 0; i < 166; i++) begin
            @(negedge CLK);
            if (i == 0 || i > 162) exp_a = 0;
            else exp_a = ((i - 1) / 5 > 31) ? 31 : (i - 1) / 5;
            chk($sformatf("addr@%0d", i), DRAddr, exp_a);
            chk($sformatf("hold@%0d", i), DRHold, i <= 162);
            chk($sformatf("done@%0d", i), DRDone, i == 162);
        end
        #1;
        chk("full_len", rx_q.size(), SLEN);
        if (rx_q.size() == SLEN) begin
            chk("full_b0", rx_q[0], 8'hA5);
            chk("full_b5", rx_q[5], 8'h05);
            chk("full_b6", rx_q[6], 8'h00);
            chk("full_b8", rx_q[8], 8'h00);
            chk("full_b125", rx_q[125], 8'hFF);
            chk("full_b128", rx_q[128], 8'hFF);
            chk("full_trailer", rx_q[129], 8'h05);
        end
        chk("full_first_edge", first_edge - e0, 1);
        chk("full_last_edge", last_edge - e0, 162);
        chk("full_done_n", done_n, 1);
        chk("full_done_edge", done_edge - e0, 162);

        // Backpressure on x1 byte 1
        start_dump();
        n = 0;
        while (!(rx_n == 6 && DRValid) && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("bp_reach", rx_n, 6);
        DRReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_byte", DRByte, 8'h00);
            chk("bp_valid", DRValid, 1);
            @(posedge CLK);
        end
        #1 DRReady = 1'b1;
        wait_done(400, 1'b0);
        chk("bp_len", rx_n, SLEN);
        chk("bp_done_edge", done_edge - e0, 165);
        chk("bp_last_edge", last_edge - e0, 165);

        // Start while busy is ignored
        start_dump();
        while (cyc < e0 + 19) begin
            @(posedge CLK);
            #1;
        end
        DRStart = 1'b1;
        @(posedge CLK);
        #1 DRStart = 1'b0;
        wait_done(400, 1'b0);
        repeat (6) @(posedge CLK);
        #1;
        chk("busy_len", rx_n, SLEN);
        chk("busy_done_n", done_n, 1);
        chk("busy_idle", DRBusy, 0);

        // Reset mid-dump, then restart with random contents
        for (int r = 0; r < NR; r++) regs[r] = $urandom;
        start_dump();
        n = 0;
        while (rx_n < 40 && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("rst_reach", rx_n, 40);
        RST = 1'b1;
        #1;
        check_zero_outputs("midrst");
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (2) @(posedge CLK);
        chk("rst_no_more", rx_n, 40);
        start_dump();
        wait_done(400, 1'b0);
        chk("rst_len", rx_n, SLEN);
        chk("rst_left", exp_q.size(), 0);
        if (rx_q.size() > 0) chk("rst_hdr", rx_q[0], 8'hA5);

        // Random contents with random backpressure
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < NR; r++) regs[r] = $urandom;
            start_dump();
            wait_done(2000, 1'b1);
            chk("rnd_len", rx_n, SLEN);
            chk("rnd_left", exp_q.size(), 0);
            chk("rnd_done_n", done_n, 1);
            chk("rnd_addr0", DRAddr, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
